// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives a 4-input logic block through all 16 vectors and compares the measured table.
// Optional early abort on the first wrong output bit is enabled by defining SWEEP_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  output logic        dut_in1,
  output logic        dut_in2,
  output logic        dut_in3,
  output logic        dut_in4,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] work_q, work_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] table_q, table_d;
  logic        pass_q, pass_d;
  logic [4:0]  mm_q, mm_d;
  logic [15:0] cmp_mask;
  logic [15:0] diff;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
    return c;
  endfunction

  // Only vectors actually sampled take part in the comparison; after an abort
  // idx_q still points at the failing vector.
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign cmp_mask = 16'hFFFF >> (4'd15 - idx_q);
`else
  assign cmp_mask = 16'hFFFF;
`endif
  assign diff = (work_q ^ exp_q) & cmp_mask;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    work_d  = work_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    pass_d  = pass_q;
    mm_d    = mm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = 4'd0;
          cnt_d   = SETTLE_INIT;
          exp_d   = expected;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          work_d[idx_q] = dut_out;
`ifdef SWEEP_STOP_ON_FAIL_EN
          if (dut_out != exp_q[idx_q]) begin
            state_d = FINISH;
          end else if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_INIT;
          end else begin
            state_d = FINISH;
          end
`else
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
            cnt_d = SETTLE_INIT;
          end else begin
            state_d = FINISH;
          end
`endif
        end
      end
      FINISH: begin
        table_d = work_q;
        mm_d    = popcount16(diff);
        pass_d  = (diff == 16'd0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      work_q  <= work_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
    end
  end

  assign dut_in1        = idx_q[3];
  assign dut_in2        = idx_q[2];
  assign dut_in3        = idx_q[1];
  assign dut_in4        = idx_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed sweeps against a table-driven logic block model,
// scoreboard queues checked by done-triggered monitors.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic        pss;
    logic [4:0]  mm;
    logic [31:0] done_cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance with SETTLE_CYCLES=2 driving a table model
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  logic        i1, i2, i3, i4, dut_out, busy, done, pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [1:0]  state_dbg;
  logic [15:0] dut_tab = 16'h279F;
  logic [3:0]  vec;
  assign vec     = {i1, i2, i3, i4};
  assign dut_out = dut_tab[vec];

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .dut_in1(i1), .dut_in2(i2), .dut_in3(i3), .dut_in4(i4),
    .dut_out(dut_out), .busy(busy), .done(done), .table_out(table_out),
    .pass(pass), .mismatch_count(mismatch_count), .state_dbg(state_dbg)
  );

  // instance with SETTLE_CYCLES=0 and the logic block output tied high
  logic        start0 = 1'b0;
  logic [15:0] expected0 = '0;
  logic        j1, j2, j3, j4, busy0, done0, pass0;
  logic [15:0] table_out0;
  logic [4:0]  mismatch_count0;
  logic [1:0]  state_dbg0;

  truth_table_sweeper #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0),
    .dut_in1(j1), .dut_in2(j2), .dut_in3(j3), .dut_in4(j4),
    .dut_out(1'b1), .busy(busy0), .done(done0), .table_out(table_out0),
    .pass(pass0), .mismatch_count(mismatch_count0), .state_dbg(state_dbg0)
  );

  resp_t sb_q[$];
  resp_t sb0_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int st_edge = 0;
  int st_edge0 = 0;
  logic step_chk = 1'b0;
  logic step0_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // monitors: pop one expected result per done pulse
  always @(negedge clk) begin
    resp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("table_out", 32'(table_out), 32'(e.tbl));
        check("pass", 32'(pass), 32'(e.pss));
        check("mismatch_count", 32'(mismatch_count), 32'(e.mm));
        check("done_cycle", 32'(cyc), e.done_cyc);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    resp_t e;
    if (done0) begin
      if (sb0_q.size() == 0) begin
        check("spurious_done0", 32'd1, 32'd0);
      end else begin
        e = sb0_q.pop_front();
        check("table_out0", 32'(table_out0), 32'(e.tbl));
        check("pass0", 32'(pass0), 32'(e.pss));
        check("mismatch_count0", 32'(mismatch_count0), 32'(e.mm));
        check("done_cycle0", 32'(cyc), e.done_cyc);
      end
    end
  end

  // vector stepping: index advances every SETTLE_CYCLES+1 cycles, holds 15 in the last cycle
  always @(negedge clk) begin
    int v;
    if (step_chk && busy) begin
      v = (cyc - st_edge) / 3;
      if (v > 15) v = 15;
      check("dut_in_step", 32'({i1, i2, i3, i4}), 32'(v));
    end
    if (step0_chk && busy0) begin
      v = cyc - st_edge0;
      if (v > 15) v = 15;
      check("dut_in_step0", 32'({j1, j2, j3, j4}), 32'(v));
    end
  end

  task automatic go(input logic [15:0] exp_word, input logic [15:0] want_tbl,
                    input logic want_pass, input logic [4:0] want_mm, input int lat,
                    input logic push);
    resp_t r;
    @(negedge clk);
    start    = 1'b1;
    expected = exp_word;
    st_edge  = cyc + 1;
    r.tbl = want_tbl; r.pss = want_pass; r.mm = want_mm; r.done_cyc = 32'(st_edge + lat);
    if (push) sb_q.push_back(r);
    @(negedge clk);
    start    = 1'b0;
    expected = ~exp_word;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && sb0_q.size() == 0 && !busy && !busy0) return;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    resp_t r;
    int lat_full;
    lat_full = 49;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dut_in", 32'({i1, i2, i3, i4}), 32'd0);
    check("rst_table", 32'(table_out), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_mm", 32'(mismatch_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // 1: matching table, vector stepping checked every cycle
    step_chk = 1'b1;
    go(16'h279F, 16'h279F, 1'b1, 5'd0, lat_full, 1'b1);
    wait_idle();
    step_chk = 1'b0;

    // 2: single-bit difference
`ifdef SWEEP_STOP_ON_FAIL_EN
    go(16'h279E, 16'h0001, 1'b0, 5'd1, 4, 1'b1);
`else
    go(16'h279E, 16'h279F, 1'b0, 5'd1, lat_full, 1'b1);
`endif
    wait_idle();

    // 3: every bit wrong, count must reach 16 without wrapping
`ifdef SWEEP_STOP_ON_FAIL_EN
    go(16'hD860, 16'h0001, 1'b0, 5'd1, 4, 1'b1);
`else
    go(16'hD860, 16'h279F, 1'b0, 5'd16, lat_full, 1'b1);
`endif
    wait_idle();

    // 4: start pulses while busy are dropped; start on the done cycle is accepted
    go(16'h279F, 16'h279F, 1'b1, 5'd0, lat_full, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd1, 32'd0);
    end
    start    = 1'b1;
    expected = 16'h279F;
    st_edge  = cyc + 1;
    r.tbl = 16'h279F; r.pss = 1'b1; r.mm = 5'd0; r.done_cyc = 32'(st_edge + lat_full);
    sb_q.push_back(r);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done_start", 32'(busy), 32'd1);
    wait_idle();

    // 5: reset in the middle of a sweep discards everything
    go(16'h279F, 16'h0000, 1'b0, 5'd0, lat_full, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        if ({i1, i2, i3, i4} == 4'd7) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) check("idx7_timeout", 32'd1, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dut_in", 32'({i1, i2, i3, i4}), 32'd0);
    check("midrst_table", 32'(table_out), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_mm", 32'(mismatch_count), 32'd0);
    repeat (60) @(negedge clk);
    check("midrst_idle_state", 32'(state_dbg), 32'd0);
`ifdef SWEEP_STOP_ON_FAIL_EN
    go(16'h0000, 16'h0001, 1'b0, 5'd1, 4, 1'b1);
`else
    go(16'h0000, 16'h279F, 1'b0, 5'd10, lat_full, 1'b1);
`endif
    wait_idle();

    // 6: zero settle time, block output tied high
    step0_chk = 1'b1;
    @(negedge clk);
    start0    = 1'b1;
    expected0 = 16'hFFFF;
    st_edge0  = cyc + 1;
    r.tbl = 16'hFFFF; r.pss = 1'b1; r.mm = 5'd0; r.done_cyc = 32'(st_edge0 + 17);
    sb0_q.push_back(r);
    @(negedge clk);
    start0    = 1'b0;
    expected0 = 16'h0000;
    wait_idle();
    step0_chk = 1'b0;

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("sb0_drained", 32'(sb0_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
